// File: rtl/rom_load_ctrl.sv
// ROM/config download sequencer between hps_io and the arcade core.
// Forwards ROM bytes, latches title/DIP bytes, and owns the core reset.
module rom_load_ctrl #(
    parameter int          ROM_AW     = 17,
    parameter int unsigned ROM_SIZE   = 'h1C000,
    parameter int unsigned SETTLE_CYC = 64
) (
    input  logic              clk_sys,
    input  logic              RESET_N,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    input  logic              user_reset,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_ad,
    output logic [7:0]        rom_dt,
    output logic              core_reset,
    output logic [3:0]        tno,
    output logic [7:0]        dsw0,
    output logic [7:0]        dsw1,
    output logic [7:0]        dsw2,
    output logic              load_done,
    output logic              dl_error
);

    localparam int CW = $clog2(ROM_SIZE + 1);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] SIZE_C      = CW'(ROM_SIZE);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t            r_state;
    logic              r_dl_prev;
    logic [CW-1:0]     r_byte_cnt;
    logic [SW-1:0]     r_settle;
    logic              r_err;
    logic              r_rom_we;
    logic [ROM_AW-1:0] r_rom_ad;
    logic [7:0]        r_rom_dt;
    logic              r_core_reset;
    logic [3:0]        r_tno;
    logic [7:0]        r_dsw0;
    logic [7:0]        r_dsw1;
    logic [7:0]        r_dsw2;
    logic              r_load_done;
    logic              r_dl_error;

    logic              w_dl_rise;
    logic              w_dl_fall;
    logic              w_rom_wr;
    logic              w_in_range;
    logic              w_accept;
    logic [CW-1:0]     w_cnt_next;
    logic              w_err_next;
    logic              w_image_ok;

    assign w_dl_rise  = ioctl_download & ~r_dl_prev;
    assign w_dl_fall  = ~ioctl_download & r_dl_prev;
    assign w_rom_wr   = (r_state == S_LOAD) && ioctl_wr && (ioctl_index == 8'd0);
    assign w_in_range = ioctl_addr < 25'(ROM_SIZE);
    assign w_accept   = w_rom_wr & w_in_range;
    assign w_err_next = r_err | (w_rom_wr & ~w_in_range);

    // Count and error include a write landing in the same cycle as the download end,
    // so the exit decision below sees the final image state.
    always_comb begin
        w_cnt_next = r_byte_cnt;
        if (w_accept && (r_byte_cnt != SIZE_C)) begin
            w_cnt_next = r_byte_cnt + CW'(1);
        end
    end

    assign w_image_ok = ~w_err_next && (w_cnt_next == SIZE_C);

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= S_IDLE;
            r_dl_prev    <= 1'b0;
            r_byte_cnt   <= '0;
            r_settle     <= '0;
            r_err        <= 1'b0;
            r_rom_we     <= 1'b0;
            r_rom_ad     <= '0;
            r_rom_dt     <= '0;
            r_core_reset <= 1'b1;
            r_tno        <= '0;
            r_dsw0       <= '0;
            r_dsw1       <= '0;
            r_dsw2       <= '0;
            r_load_done  <= 1'b0;
            r_dl_error   <= 1'b0;
        end else begin
            r_dl_prev <= ioctl_download;
            r_rom_we  <= 1'b0;
            if (w_accept) begin
                r_rom_we <= 1'b1;
                r_rom_ad <= ioctl_addr[ROM_AW-1:0];
                r_rom_dt <= ioctl_dout;
            end

            // Title and DIP bytes are accepted whatever the sequencer is doing.
            if (ioctl_wr && (ioctl_index == 8'd1) && (ioctl_addr == 25'd0)) begin
                r_tno <= ioctl_dout[3:0];
            end
            if (ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0)) begin
                case (ioctl_addr[2:0])
                    3'd0:    r_dsw0 <= ioctl_dout;
                    3'd1:    r_dsw1 <= ioctl_dout;
                    3'd2:    r_dsw2 <= ioctl_dout;
                    default: ;
                endcase
            end

            if (w_dl_rise && (r_state != S_LOAD)) begin
                r_state      <= S_LOAD;
                r_byte_cnt   <= '0;
                r_err        <= 1'b0;
                r_dl_error   <= 1'b0;
                r_load_done  <= 1'b0;
                r_core_reset <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_LOAD: begin
                        r_byte_cnt <= w_cnt_next;
                        r_err      <= w_err_next;
                        if (w_dl_fall) begin
                            if (w_image_ok) begin
                                r_state  <= S_SETTLE;
                                r_settle <= '0;
                            end else begin
                                r_state     <= S_FAIL;
                                r_dl_error  <= 1'b1;
                                r_load_done <= 1'b0;
                            end
                        end
                    end
                    S_SETTLE: begin
                        if (user_reset) begin
                            r_settle <= '0;
                        end else if (r_settle == SETTLE_LAST) begin
                            r_state      <= S_RUN;
                            r_load_done  <= 1'b1;
                            r_core_reset <= 1'b0;
                        end else begin
                            r_settle <= r_settle + SW'(1);
                        end
                    end
                    S_RUN: begin
                        if (user_reset) begin
                            r_state      <= S_SETTLE;
                            r_settle     <= '0;
                            r_core_reset <= 1'b1;
                        end
                    end
                    S_FAIL: ;
                    default: begin
                        r_state      <= S_IDLE;
                        r_core_reset <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign rom_we     = r_rom_we;
    assign rom_ad     = r_rom_ad;
    assign rom_dt     = r_rom_dt;
    assign core_reset = r_core_reset;
    assign tno        = r_tno;
    assign dsw0       = r_dsw0;
    assign dsw1       = r_dsw1;
    assign dsw2       = r_dsw2;
    assign load_done  = r_load_done;
    assign dl_error   = r_dl_error;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl; the image size is shrunk to keep each download short.
module tb_rom_load_ctrl;

    localparam int unsigned SIZE   = 'h200;
    localparam int unsigned SETTLE = 64;

    logic        clk_sys = 1'b0;
    logic        RESET_N = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        user_reset = 1'b0;
    logic        rom_we;
    logic [16:0] rom_ad;
    logic [7:0]  rom_dt;
    logic        core_reset;
    logic [3:0]  tno;
    logic [7:0]  dsw0, dsw1, dsw2;
    logic        load_done;
    logic        dl_error;

    int checks = 0;
    int failures = 0;
    int we, bad, cyc, lows, weSeen, rstSeen;

    rom_load_ctrl #(
        .ROM_AW    (17),
        .ROM_SIZE  (SIZE),
        .SETTLE_CYC(SETTLE)
    ) dut (
        .clk_sys       (clk_sys),
        .RESET_N       (RESET_N),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_index   (ioctl_index),
        .user_reset    (user_reset),
        .rom_we        (rom_we),
        .rom_ad        (rom_ad),
        .rom_dt        (rom_dt),
        .core_reset    (core_reset),
        .tno           (tno),
        .dsw0          (dsw0),
        .dsw1          (dsw1),
        .dsw2          (dsw2),
        .load_done     (load_done),
        .dl_error      (dl_error)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic dl, input logic wr, input logic [7:0] idx,
                                 input logic [24:0] addr, input logic [7:0] dout);
        ioctl_download = dl;
        ioctl_wr       = wr;
        ioctl_index    = idx;
        ioctl_addr     = addr;
        ioctl_dout     = dout;
    endtask

    // Streams index-0 bytes with data = addr[7:0] and checks each 1-cycle-late rom_we.
    task automatic writeBytes(input int first, input int n, input bit fallWithLast,
                              output int weCount, output int badCount);
        weCount  = 0;
        badCount = 0;
        for (int a = first; a < first + n; a++) begin
            automatic logic [24:0] ad = 25'(a);
            applyStimulus(!(fallWithLast && (a == first + n - 1)), 1'b1, 8'd0, ad, ad[7:0]);
            tick();
            if (rom_we === 1'b1) weCount++;
            if ((rom_we !== 1'b1) || (rom_ad !== ad[16:0]) || (rom_dt !== ad[7:0])) badCount++;
        end
        ioctl_wr = 1'b0;
    endtask

    task automatic waitRelease(output int cycles);
        cycles = 0;
        while ((core_reset !== 1'b0) && (cycles < 300)) begin
            tick();
            cycles++;
        end
    endtask

    task automatic watchHeld(input int n, output int lowCount);
        lowCount = 0;
        for (int c = 0; c < n; c++) begin
            user_reset = (c >= 20) && (c < 30);
            tick();
            if (core_reset !== 1'b1) lowCount++;
        end
        user_reset = 1'b0;
    endtask

    initial begin
        // Reset values
        #2 RESET_N = 1'b0;
        #1;
        checkOutput("rst_core_reset", 32'(core_reset), 1);
        checkOutput("rst_rom", {rom_we, rom_ad, rom_dt}, 0);
        checkOutput("rst_cfg", {tno, dsw0, dsw1, dsw2}, 0);
        checkOutput("rst_flags", {load_done, dl_error}, 0);
        repeat (2) tick();
        RESET_N = 1'b1;
        repeat (3) tick();
        checkOutput("idle_core_reset", 32'(core_reset), 1);

        // Nominal load
        applyStimulus(1'b1, 1'b0, 8'd0, 25'd0, 8'd0);
        tick();
        writeBytes(0, SIZE, 1'b0, we, bad);
        checkOutput("nom_we_count", we, SIZE);
        checkOutput("nom_data_bad", bad, 0);
        checkOutput("nom_held_in_load", {core_reset, load_done}, 2'b10);
        applyStimulus(1'b0, 1'b0, 8'd0, 25'd0, 8'd0);
        waitRelease(cyc);
        checkOutput("nom_release_cycles", cyc, SETTLE + 1);
        checkOutput("nom_flags", {load_done, dl_error}, 2'b10);

        // Config writes in RUN
        weSeen = 0;
        rstSeen = 0;
        applyStimulus(1'b0, 1'b1, 8'd1, 25'd0, 8'h23);
        tick();
        if (rom_we !== 1'b0) weSeen++;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd254, 25'(i), 8'(8'hA0 + i));
            tick();
            if (rom_we !== 1'b0) weSeen++;
            if (core_reset !== 1'b0) rstSeen++;
        end
        applyStimulus(1'b0, 1'b1, 8'd1, 25'd1, 8'h35);
        tick();
        applyStimulus(1'b0, 1'b1, 8'd254, 25'd8, 8'h55);
        tick();
        applyStimulus(1'b0, 1'b1, 8'd7, 25'd0, 8'h99);
        tick();
        if (rom_we !== 1'b0) weSeen++;
        applyStimulus(1'b0, 1'b0, 8'd0, 25'd0, 8'd0);
        tick();
        checkOutput("cfg_tno", 32'(tno), 3);
        checkOutput("cfg_dsw0", 32'(dsw0), 'hA0);
        checkOutput("cfg_dsw1", 32'(dsw1), 'hA1);
        checkOutput("cfg_dsw2", 32'(dsw2), 'hA2);
        checkOutput("cfg_no_rom_we", weSeen, 0);
        checkOutput("cfg_core_running", rstSeen + 32'(core_reset), 0);

        // User reset stretch
        user_reset = 1'b1;
        tick();
        checkOutput("ures_assert", 32'(core_reset), 1);
        repeat (9) tick();
        user_reset = 1'b0;
        waitRelease(cyc);
        checkOutput("ures_release_cycles", cyc, SETTLE);
        checkOutput("ures_load_done", 32'(load_done), 1);

        // Download edge beats user_reset, then a short image
        ioctl_download = 1'b1;
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        checkOutput("prio_enters_load", {core_reset, load_done}, 2'b10);
        writeBytes(0, SIZE - 1, 1'b0, we, bad);
        checkOutput("short_we_count", we, SIZE - 1);
        applyStimulus(1'b0, 1'b0, 8'd0, 25'd0, 8'd0);
        watchHeld(150, lows);
        checkOutput("short_held", lows, 0);
        checkOutput("short_flags", {load_done, dl_error}, 2'b01);

        // Recovery with the download end on the last write
        applyStimulus(1'b1, 1'b0, 8'd0, 25'd0, 8'd0);
        tick();
        checkOutput("recover_err_cleared", 32'(dl_error), 0);
        writeBytes(0, SIZE, 1'b1, we, bad);
        checkOutput("recover_we_count", we, SIZE);
        checkOutput("recover_data_bad", bad, 0);
        waitRelease(cyc);
        checkOutput("fall_with_last_cycles", cyc, SETTLE);
        checkOutput("recover_flags", {load_done, dl_error}, 2'b10);

        // Overflow write past the image
        applyStimulus(1'b1, 1'b0, 8'd0, 25'd0, 8'd0);
        tick();
        writeBytes(0, SIZE, 1'b0, we, bad);
        applyStimulus(1'b1, 1'b1, 8'd0, 25'(SIZE), 8'h5A);
        tick();
        checkOutput("ovf_no_we", 32'(rom_we), 0);
        applyStimulus(1'b0, 1'b0, 8'd0, 25'd0, 8'd0);
        watchHeld(100, lows);
        checkOutput("ovf_held", lows, 0);
        checkOutput("ovf_flags", {load_done, dl_error}, 2'b01);

        // Async reset mid-load
        applyStimulus(1'b1, 1'b0, 8'd0, 25'd0, 8'd0);
        tick();
        writeBytes(0, 'h100, 1'b0, we, bad);
        checkOutput("arst_pre_we_count", we, 'h100);
        applyStimulus(1'b0, 1'b0, 8'd0, 25'd0, 8'd0);
        #1 RESET_N = 1'b0;
        #1;
        checkOutput("arst_rom", {rom_we, rom_ad, rom_dt}, 0);
        checkOutput("arst_cfg", {tno, dsw0, dsw1, dsw2}, 0);
        checkOutput("arst_core_reset", 32'(core_reset), 1);
        checkOutput("arst_flags", {load_done, dl_error}, 0);
        RESET_N = 1'b1;
        watchHeld(100, lows);
        checkOutput("arst_idle_held", lows, 0);
        applyStimulus(1'b1, 1'b0, 8'd0, 25'd0, 8'd0);
        tick();
        writeBytes(0, SIZE, 1'b0, we, bad);
        applyStimulus(1'b0, 1'b0, 8'd0, 25'd0, 8'd0);
        waitRelease(cyc);
        checkOutput("arst_reload_cycles", cyc, SETTLE + 1);
        checkOutput("arst_reload_flags", {load_done, dl_error}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
- Sequences ROM/config download from hps_io into the arcade core, and owns the core reset.
- Decodes ioctl traffic per index: 0 = ROM image, 1 = title number, 254 = DIP bytes.
- Forwards ROM bytes to the core loader port with a 1-cycle registered pipeline.
- Holds the core in reset until a complete, valid image has loaded and a settle interval has elapsed; also stretches the user/OSD reset.

Parameters:
- ROM_AW, 17: width of the ROM write address to the core.
- ROM_SIZE, 17'h1C000: expected image length in bytes. An index-0 write at addr ≥ ROM_SIZE is an error.
- SETTLE_CYC, 64: number of clk_sys cycles core_reset is held after load end or after a user reset.

Ports:
- clk_sys  in  1  system clock (48 MHz)
- RESET_N  in  1  asynchronous, active-low reset
- ioctl_download  in  1  download in progress
- ioctl_wr  in  1  1-cycle write strobe
- ioctl_addr  in  25  byte address within the current index
- ioctl_dout  in  8  write data
- ioctl_index  in  8  download index
- user_reset  in  1  OSD/button reset request, level
- rom_we  out  1  ROM write strobe to the core
- rom_ad  out  ROM_AW  ROM write address
- rom_dt  out  8  ROM write data
- core_reset  out  1  active-high reset to the game core
- tno  out  4  title/model number
- dsw0, dsw1, dsw2  out  8 each  DIP bytes 0..2
- load_done  out  1  a valid image is resident
- dl_error  out  1  last image was invalid

Behaviour:
- Reset (RESET_N=0, async):
  - state=IDLE; core_reset=1; rom_we=0; rom_ad=0; rom_dt=0.
  - tno=0; dsw0..2=0; load_done=0; dl_error=0.
  - Byte counter=0; settle counter=0.
- FSM states: IDLE, LOAD, SETTLE, RUN, FAIL. core_reset=1 in every state except RUN.
- IDLE:
  - Rising edge of ioctl_download (registered previous value) → LOAD.
- LOAD entry, on the same edge:
  - Byte counter cleared; dl_error cleared; load_done cleared.
- LOAD, index 0, ioctl_wr=1:
  - If addr < ROM_SIZE: next cycle rom_we=1, rom_ad=addr[ROM_AW-1:0], rom_dt=dout; byte counter +1 (saturates at ROM_SIZE).
  - If addr ≥ ROM_SIZE: no rom_we; sticky error flag set.
  - rom_we is high exactly 1 cycle per accepted strobe; back-to-back strobes give back-to-back rom_we.
- Index 1 write with addr==0, in any state: tno <= dout[3:0]. Other addresses are ignored. No rom_we.
- Index 254 write with addr[24:3]==0, in any state:
  - addr[2:0] of 0, 1, 2 → dsw0, dsw1, dsw2; addresses 3..7 are ignored.
  - These writes never affect the byte count or the FSM.
- Writes with any other index: ignored.
- LOAD exit: falling edge of ioctl_download → SETTLE when the error flag is clear and the byte count == ROM_SIZE; otherwise → FAIL.
- A falling edge in the same cycle as a last ioctl_wr: that write is counted first, then the decision is made.
- SETTLE:
  - Settle counter counts 0..SETTLE_CYC-1, then → RUN with load_done=1.
  - A rising download edge during SETTLE → LOAD (restart).
- RUN:
  - core_reset=0.
  - user_reset=1 → SETTLE with counter cleared. While user_reset stays high, the counter is held at 0, so release occurs SETTLE_CYC cycles after user_reset falls.
  - Rising download edge → LOAD.
- FAIL:
  - dl_error=1; load_done=0; core_reset=1.
  - Only a rising download edge (→ LOAD) leaves FAIL; user_reset is ignored.
- Download edge and user_reset in the same cycle: the download edge has priority.
- RESET_N asserted mid-LOAD: everything returns to reset values; the partial image is discarded (load_done=0).
- Latency:
  - ioctl_wr → rom_we: 1 cycle.
  - Download end → core_reset low: 1 + SETTLE_CYC cycles.

Test Plan:
- Nominal load: download index 0, addresses 0..ROM_SIZE-1, data = addr[7:0], then drop ioctl_download.
  - → rom_we count = 0x1C000, each rom_ad/rom_dt matching, 1-cycle lag.
  - → core_reset falls exactly 65 cycles after the falling edge; load_done=1.
- Short image: stop at 0x1BFFF bytes.
  - → FAIL; dl_error=1; core_reset stays 1 indefinitely.
  - A following full download → RUN and dl_error=0.
- Overflow: a full image plus one write at addr 0x1C000.
  - → no rom_we for that write; FAIL; dl_error=1.
- Config writes during RUN: index 1 addr 0 data 8'h23 → tno=3. Index 254 addr 0..7 data 8'hA0..A7 → dsw0=A0, dsw1=A1, dsw2=A2.
  - → core_reset stays 0; no rom_we.
- User reset: in RUN, pulse user_reset high 10 cycles.
  - → core_reset=1 from the next cycle until 64 cycles after user_reset falls.
  - A download edge in the same cycle as user_reset → LOAD.
- Async reset mid-load: assert RESET_N=0 for 1 ns during LOAD at byte 0x100.
  - → all outputs at reset values immediately, without waiting for a clock edge.
  - → state IDLE; a new download is required before core_reset deasserts.
